// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths, entry layout and constants for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W  = 7;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               misalign;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with push/pop/flush and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Fetches instructions for incoming PCs and queues {PC, instr} to decode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          inpPC,
    input  logic                       pcValid,
    output logic                       pcReady,
    output logic                       imemRdEn,
    output logic [ADDR_W-3:0]          imemAddr,
    input  logic [INSTR_W-1:0]         imemData,
    input  logic                       flush,
    output logic [INSTR_W-1:0]         outInstr,
    output logic [ADDR_W-1:0]          outPC,
    output logic                       outMisalign,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import fetch_pkg::*;

    logic              r_inflight_valid;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight_misalign;
    logic              w_room;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head_entry;

    // The in-flight read holds a slot so the FIFO can never overflow.
    assign w_room   = (32'(count) + 32'(r_inflight_valid)) < 32'(DEPTH);
    assign pcReady  = rst && !flush && w_room;
    assign w_accept = pcValid && pcReady;
    assign imemRdEn = w_accept;
    assign imemAddr = inpPC[ADDR_W-1:2];

    // flush forces w_accept low, which also empties the in-flight slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight_valid    <= 1'b0;
            r_inflight_pc       <= '0;
            r_inflight_misalign <= 1'b0;
        end else begin
            r_inflight_valid <= w_accept;
            if (w_accept) begin
                r_inflight_pc       <= inpPC;
                r_inflight_misalign <= |inpPC[1:0];
            end
        end
    end

    assign w_push_entry.pc       = r_inflight_pc;
    assign w_push_entry.instr    = imemData;
    assign w_push_entry.misalign = r_inflight_misalign;

    assign w_push = r_inflight_valid && !flush;
    assign w_pop  = outValid && outReady;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (flush),
        .pop_data  (w_head_entry),
        .empty     (w_fifo_empty),
        .count     (count)
    );

    assign outValid    = !w_fifo_empty;
    assign outInstr    = outValid ? w_head_entry.instr    : NOP_INSTR;
    assign outPC       = outValid ? w_head_entry.pc       : '0;
    assign outMisalign = outValid ? w_head_entry.misalign : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Scoreboard bench for instr_fetch_queue with a 1-cycle imem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int ADDR_W  = 7;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  inpPC;
    logic               pcValid;
    logic               pcReady;
    logic               imemRdEn;
    logic [ADDR_W-3:0]  imemAddr;
    logic [INSTR_W-1:0] imemData;
    logic               flush;
    logic [INSTR_W-1:0] outInstr;
    logic [ADDR_W-1:0]  outPC;
    logic               outMisalign;
    logic               outValid;
    logic               outReady;
    logic [2:0]         count;

    instr_fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inpPC       (inpPC),
        .pcValid     (pcValid),
        .pcReady     (pcReady),
        .imemRdEn    (imemRdEn),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .flush       (flush),
        .outInstr    (outInstr),
        .outPC       (outPC),
        .outMisalign (outMisalign),
        .outValid    (outValid),
        .outReady    (outReady),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word w holds 32'hA0 + w; garbage when not read.
    always @(posedge clk) begin
        imemData <= imemRdEn ? (32'hA0 + 32'(imemAddr)) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               mis;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   pop_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_acc_first = -1;
    int   waits;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every handshake, checks zero-gating when idle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (outValid === 1'b1) begin
                if (outReady && !flush) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got pc %0h, expected no output", outPC);
                    end else begin
                        m_e = sb.pop_front();
                        check("out_pc", 64'(outPC), 64'(m_e.pc));
                        check("out_instr", 64'(outInstr), 64'(m_e.instr));
                        check("out_misalign", 64'(outMisalign), 64'(m_e.mis));
                        pop_cyc.push_back(cyc);
                    end
                end
            end else begin
                check("idle_zero", 64'({outInstr, outPC, outMisalign}), 64'd0);
            end
        end
    end

    task automatic offer(input logic [ADDR_W-1:0] pc, output int n_wait);
        bit done;
        done   = 1'b0;
        n_wait = 0;
        pcValid = 1'b1;
        inpPC   = pc;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (pcReady) begin
                sb.push_back('{pc, 32'hA0 + 32'(pc[ADDR_W-1:2]), |pc[1:0]});
                check("rd_en", 64'(imemRdEn), 64'd1);
                check("rd_addr", 64'(imemAddr), 64'(pc[ADDR_W-1:2]));
                if (t_acc_first < 0) t_acc_first = cyc;
                done = 1'b1;
            end else begin
                n_wait++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL offer_timeout: pc %0h never accepted, expected acceptance", pc);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !outValid && count == 3'd0) ok = 1'b1;
        end
        check(name, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        pcValid  = 1'b1;
        inpPC    = 7'h00;
        flush    = 1'b0;
        outReady = 1'b0;

        // 1: reset holds everything idle even with pcValid high
        repeat (3) @(negedge clk);
        check("rst_pcready", 64'(pcReady), 64'd0);
        check("rst_rden", 64'(imemRdEn), 64'd0);
        check("rst_outvalid", 64'(outValid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_outs", 64'({outInstr, outPC, outMisalign}), 64'd0);
        @(posedge clk); #1;
        pcValid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("rel_pcready", 64'(pcReady), 64'd1);
        @(posedge clk); #1;

        // 2: streaming, 2-cycle latency, back-to-back outputs
        outReady    = 1'b1;
        t_acc_first = -1;
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            offer(7'(i * 4), waits);
            check("stream_waits", 64'(waits), 64'd0);
        end
        pcValid = 1'b0;
        wait_drain("t2_drain");
        check("t2_npop", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4) begin
            check("t2_latency", 64'(pop_cyc[0] - t_acc_first), 64'd2);
            check("t2_b2b", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
        end

        // 3: backpressure fills the queue, further offers refused
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) offer(7'(i * 4), waits);
        for (int i = 0; i < 6; i++) begin
            pcValid = 1'b1;
            inpPC   = (i < 3) ? 7'h10 : 7'h14;
            @(negedge clk);
            check("full_block", 64'(pcReady), 64'd0);
            @(posedge clk); #1;
        end
        check("full_count", 64'(count), 64'd4);
        pcValid  = 1'b0;
        outReady = 1'b1;
        wait_drain("t3_drain");

        // 4: from full, stream 10 more through the wrapping pointers
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) offer(7'(8'h40 + i * 4), waits);
        repeat (2) @(posedge clk);
        #1;
        check("t4_full", 64'(count), 64'd4);
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) offer(7'(8'h50 + i * 4), waits);
        pcValid = 1'b0;
        wait_drain("t4_drain");

        // 5: flush while the 7'h10 read is returning
        offer(7'h10, waits);
        flush   = 1'b1;
        sb.delete();
        pcValid = 1'b1;
        inpPC   = 7'h14;
        @(negedge clk);
        check("flush_pcready", 64'(pcReady), 64'd0);
        check("flush_rden", 64'(imemRdEn), 64'd0);
        @(posedge clk); #1;
        flush   = 1'b0;
        pcValid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_outvalid", 64'(outValid), 64'd0);
        offer(7'h14, waits);
        pcValid = 1'b0;
        wait_drain("t5_drain");

        // 6: misaligned PC, then asynchronous reset mid-stream
        offer(7'h06, waits);
        pcValid = 1'b0;
        wait_drain("t6_drain");
        outReady = 1'b0;
        offer(7'h20, waits);
        offer(7'h24, waits);
        offer(7'h28, waits);
        pcValid = 1'b1;
        inpPC   = 7'h2C;
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("arst_outvalid", 64'(outValid), 64'd0);
        check("arst_outs", 64'({outInstr, outPC, outMisalign}), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_pcready", 64'(pcReady), 64'd0);
        check("arst_rden", 64'(imemRdEn), 64'd0);
        @(posedge clk); #1;
        pcValid = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_outvalid", 64'(outValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
